// File: rtl/video_out_pkg.sv
// video_out_pkg: shared helpers for the video output stage (colour expansion, counter widths, bar colours)
package video_out_pkg;

    function automatic int pos_width(input int span);
        return $clog2(span) + 1;
    endfunction

    function automatic logic [7:0] expand_color(input logic [7:0] c, input int bits);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = c[3'(bits - 1 - (k % bits))];
        return r;
    endfunction

`ifdef VIDEO_TEST_PATTERN_EN
    // index 0..7: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };
`endif

endpackage

// File: rtl/video_ce_div.sv
// video_ce_div: pixel clock-enable, one pulse every CE_DIV clk_sys cycles
module video_ce_div #(
    parameter int CE_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    output logic ce_pix
);
    localparam int DW = $clog2(CE_DIV);
    localparam logic [DW-1:0] LAST = DW'(CE_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk_sys)
        if (reset) div <= '0;
        else div <= (div == LAST) ? '0 : div + DW'(1);

    assign ce_pix = div == LAST;
endmodule

// File: rtl/video_out_adapter.sv
// video_out_adapter: core RGB/sync to emu video ports with colour expansion, sync normalisation and blanking/DE
// VIDEO_TEST_PATTERN_EN adds a test_pattern input that replaces colour with 8 vertical bars
module video_out_adapter
    import video_out_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int CE_DIV     = 4,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int SYNC_NEG   = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
`ifdef VIDEO_TEST_PATTERN_EN
    input  logic                  test_pattern,
`endif
    input  logic [COLOR_BITS-1:0] r_in,
    input  logic [COLOR_BITS-1:0] g_in,
    input  logic [COLOR_BITS-1:0] b_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    output logic                  ce_pix,
    output logic [7:0]            r_out,
    output logic [7:0]            g_out,
    output logic [7:0]            b_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  hblank,
    output logic                  vblank,
    output logic                  de_out
);
    localparam int HW = pos_width(H_BACK + H_ACTIVE);
    localparam int VW = pos_width(V_BACK + V_ACTIVE);
    localparam logic [HW-1:0] H_START = HW'(H_BACK);
    localparam logic [HW-1:0] H_END   = HW'(H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_START = VW'(V_BACK);
    localparam logic [VW-1:0] V_END   = VW'(V_BACK + V_ACTIVE);
    localparam logic NEG = SYNC_NEG != 0;

    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic hs, vs, hs_d, vs_d, hs_end, vs_end, h_act, v_act;
    logic [7:0] r_x, g_x, b_x;

    video_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ce_pix (ce_pix)
    );

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int BAR_PIX = H_ACTIVE / 8;
    localparam int BW = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_PIX - 1);

    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar;

    // bar index restarts on every blanked pixel so the first active pixel is always bar 0
    always_ff @(posedge clk_sys)
        if (reset) begin
            bar_cnt <= '0;
            bar     <= '0;
        end else if (ce_pix) begin
            bar_cnt <= (!h_act || hs_end || bar_cnt == BAR_LAST) ? '0 : bar_cnt + BW'(1);
            bar     <= (!h_act || hs_end) ? '0 : (bar_cnt == BAR_LAST) ? bar + 3'd1 : bar;
        end
`endif

    always_comb begin
        hs     = hs_in ^ NEG;
        vs     = vs_in ^ NEG;
        hs_end = hs_d & ~hs;
        vs_end = vs_d & ~vs;
        h_act  = hpos >= H_START && hpos < H_END;
        v_act  = vpos >= V_START && vpos < V_END;
`ifdef VIDEO_TEST_PATTERN_EN
        r_x = test_pattern ? (h_act ? BAR_RGB[bar][23:16] : 8'h00) : expand_color(8'(r_in), COLOR_BITS);
        g_x = test_pattern ? (h_act ? BAR_RGB[bar][15:8]  : 8'h00) : expand_color(8'(g_in), COLOR_BITS);
        b_x = test_pattern ? (h_act ? BAR_RGB[bar][7:0]   : 8'h00) : expand_color(8'(b_in), COLOR_BITS);
`else
        r_x = expand_color(8'(r_in), COLOR_BITS);
        g_x = expand_color(8'(g_in), COLOR_BITS);
        b_x = expand_color(8'(b_in), COLOR_BITS);
`endif
    end

    always_ff @(posedge clk_sys)
        if (reset) begin
            hpos   <= '1;
            vpos   <= '1;
            hs_d   <= 1'b0;
            vs_d   <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            hblank <= 1'b1;
            vblank <= 1'b1;
            de_out <= 1'b0;
        end else if (ce_pix) begin
            hs_d   <= hs;
            vs_d   <= vs;
            // counters saturate so a missing sync leaves the output blanked instead of wrapping
            hpos   <= hs_end ? '0 : (&hpos) ? hpos : hpos + HW'(1);
            vpos   <= vs_end ? '0 : !hs_end ? vpos : (&vpos) ? vpos : vpos + VW'(1);
            r_out  <= r_x;
            g_out  <= g_x;
            b_out  <= b_x;
            hs_out <= hs;
            vs_out <= vs;
            hblank <= ~h_act;
            vblank <= ~v_act;
            de_out <= h_act & v_act;
        end
endmodule

// File: tb/tb_video_out_adapter.sv
// tb_video_out_adapter: directed stimulus with a per-cycle behavioural model and literal checkpoints
module tb_video_out_adapter;
    localparam int CB = 4, CD = 4, HB = 2, HA = 16, VB = 1, VA = 4;
    localparam int BIG = 1 << 20;

    logic clk_sys = 1'b0, reset = 1'b1;
    logic [3:0] r_in = '0, g_in = '0, b_in = '0;
    logic hs_in = 1'b1, vs_in = 1'b1, tp = 1'b0;
    logic ce_pix, hs_out, vs_out, hblank, vblank, de_out;
    logic [7:0] r_out, g_out, b_out;

    video_out_adapter #(
        .COLOR_BITS(CB), .CE_DIV(CD), .H_BACK(HB), .H_ACTIVE(HA),
        .V_BACK(VB), .V_ACTIVE(VA), .SYNC_NEG(1)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
`ifdef VIDEO_TEST_PATTERN_EN
        .test_pattern(tp),
`endif
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in),
        .ce_pix(ce_pix),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out),
        .hblank(hblank), .vblank(vblank), .de_out(de_out)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pixels since last hsync end and lines since last vsync end as plain integers
    int cyc = 0, hcnt = BIG, vcnt = BIG, m_bar;
    logic hsd = 1'b0, vsd = 1'b0;
    logic m_hs, m_vs, m_he, m_ve, m_ha, m_va;
    logic [7:0] e_r = '0, e_g = '0, e_b = '0;
    logic e_hs = 1'b0, e_vs = 1'b0, e_hb = 1'b1, e_vb = 1'b1, e_de = 1'b0;

    assign m_hs  = ~hs_in;
    assign m_vs  = ~vs_in;
    assign m_he  = hsd & ~m_hs;
    assign m_ve  = vsd & ~m_vs;
    assign m_ha  = hcnt >= HB && hcnt < HB + HA;
    assign m_va  = vcnt >= VB && vcnt < VB + VA;
    assign m_bar = (hcnt - HB) / (HA / 8);

    always @(posedge clk_sys) begin
        if (reset) begin
            cyc <= 0; hcnt <= BIG; vcnt <= BIG; hsd <= 1'b0; vsd <= 1'b0;
            e_r <= '0; e_g <= '0; e_b <= '0;
            e_hs <= 1'b0; e_vs <= 1'b0; e_hb <= 1'b1; e_vb <= 1'b1; e_de <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (cyc % CD == CD - 1) begin
                e_r  <= tp ? ((m_ha && (m_bar % 4) < 2) ? 8'hFF : 8'h00) : 8'(r_in) * 8'h11;
                e_g  <= tp ? ((m_ha && m_bar < 4) ? 8'hFF : 8'h00) : 8'(g_in) * 8'h11;
                e_b  <= tp ? ((m_ha && (m_bar % 2) == 0) ? 8'hFF : 8'h00) : 8'(b_in) * 8'h11;
                e_hs <= m_hs;
                e_vs <= m_vs;
                e_hb <= !m_ha;
                e_vb <= !m_va;
                e_de <= m_ha && m_va;
                hsd  <= m_hs;
                vsd  <= m_vs;
                hcnt <= m_he ? 0 : (hcnt < BIG ? hcnt + 1 : hcnt);
                vcnt <= m_ve ? 0 : (m_he && vcnt < BIG) ? vcnt + 1 : vcnt;
            end
        end
    end

    always @(negedge clk_sys)
        if (chk_en) begin
            check("ce_pix", 32'(ce_pix), 32'(cyc % CD == CD - 1));
            check("rgb", 32'({r_out, g_out, b_out}), 32'({e_r, e_g, e_b}));
            check("sync_blank", 32'({hs_out, vs_out, hblank, vblank, de_out}),
                  32'({e_hs, e_vs, e_hb, e_vb, e_de}));
        end

    task automatic tick();
        for (int i = 0; i < 2 * CD; i++) begin
            @(negedge clk_sys);
            if (cyc % CD == CD - 1) break;
        end
        @(posedge clk_sys);
        #1;
    endtask

    int de_cnt, hb_cnt, aa_cnt, first_hb;
    logic [23:0] rgb5, rgb7;

    task automatic line(input int len, input bit hsp, input int vs_low);
        de_cnt = 0; hb_cnt = 0; aa_cnt = 0; first_hb = -1; rgb5 = '0; rgb7 = '0;
        for (int t = 0; t < len; t++) begin
            hs_in = !(hsp && t < 2);
            vs_in = !(t < vs_low);
            r_in  = (t >= 5 && t <= 20) ? 4'hA : 4'h0;
            g_in  = 4'(t * 3);
            b_in  = 4'(t + 7);
            tick();
            if (de_out) de_cnt++;
            if (!hblank) begin
                hb_cnt++;
                if (first_hb < 0) first_hb = t;
            end
            if (r_out == 8'hAA) aa_cnt++;
            if (t == 5) rgb5 = {r_out, g_out, b_out};
            if (t == 7) rgb7 = {r_out, g_out, b_out};
        end
    endtask

    int first_ce, second_ce, total;
    int de_l[6];

    initial begin
        repeat (2) @(posedge clk_sys);
        #1 chk_en = 1'b1;
        @(negedge clk_sys);
        check("rst_de", 32'(de_out), 32'd0);
        check("rst_blank", 32'({hblank, vblank}), 32'd3);
        check("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
        check("rst_ce", 32'(ce_pix), 32'd0);

        @(posedge clk_sys);
        #1 reset = 1'b0;
        first_ce = -1; second_ce = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_sys);
            if (ce_pix) begin
                if (first_ce < 0) first_ce = k;
                else if (second_ce < 0) second_ce = k;
            end
        end
        check("first_ce", 32'(first_ce), 32'd3);
        check("second_ce", 32'(second_ce), 32'd7);

        line(24, 1'b1, 0);
        check("a_first_active", 32'(first_hb), 32'd5);
        check("a_aa_pixels", 32'(aa_cnt), 32'd16);
        check("a_hactive", 32'(hb_cnt), 32'd16);
        check("a_de_no_vsync", 32'(de_cnt), 32'd0);

        line(24, 1'b1, 24);
        total = 0;
        for (int l = 0; l < 6; l++) begin
            line(24, 1'b1, l == 0 ? 2 : 0);
            de_l[l] = de_cnt;
            total += de_cnt;
        end
        check("b_line0_vpos0", 32'(de_l[0]), 32'd0);
        check("b_line1_de", 32'(de_l[1]), 32'd16);
        check("b_line4_de", 32'(de_l[4]), 32'd16);
        check("b_line5_de", 32'(de_l[5]), 32'd0);
        check("b_frame_de", 32'(total), 32'd64);

        line(24, 1'b1, 24);
        line(24, 1'b1, 10);
        check("c_mid_vsync_de", 32'(de_cnt), 32'd0);
        line(24, 1'b1, 0);
        check("c_after_mid_de", 32'(de_cnt), 32'd16);

        line(9, 1'b1, 0);
        check("d_pre_reset_de", 32'(de_out), 32'd1);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check("d_reset_de", 32'(de_out), 32'd0);
        check("d_reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
        check("d_reset_blank", 32'({hblank, vblank}), 32'd3);
        reset = 1'b0;
        line(24, 1'b0, 0);
        check("d_nosync_hactive", 32'(hb_cnt), 32'd0);
        line(24, 1'b1, 0);
        check("d_resync_hactive", 32'(hb_cnt), 32'd16);
        check("d_resync_de", 32'(de_cnt), 32'd0);

        line(80, 1'b0, 0);
        check("e_missing_hsync", 32'(hb_cnt), 32'd0);

`ifdef VIDEO_TEST_PATTERN_EN
        tp = 1'b1;
        line(24, 1'b1, 24);
        line(24, 1'b1, 2);
        line(24, 1'b1, 0);
        check("f_bar0", 32'(rgb5), 32'hFFFFFF);
        check("f_bar1", 32'(rgb7), 32'hFFFF00);
        tp = 1'b0;
`endif

        @(negedge clk_sys);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: run did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
